// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared encodings for the AXI4-Stream test-pattern source (axis_pattern_gen):
//   - pat_e   : pattern-select encodings (bars, gradient, checkerboard, solid)
//   - state_e : frame sequencer states (idle, active frame, inter-frame gap)
//   - BAR_RGB : colour-bar palette, index 0 is the leftmost bar
// -----------------------------------------------------------------------------
package lcd_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pat_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  // Packed array: the first listed element lands at the highest index, so the
  // list runs right-to-left across the screen (BAR_RGB[0] = white).
  localparam logic [7:0][23:0] BAR_RGB = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  localparam logic [3:0] TSTRB_ALL = 4'hF;

endpackage

// File: rtl/axis_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// axis_pattern_gen_if
// AXI4-Stream video bus between the pattern source and the LCD FIFO.
//   tdata  [31:0] : {8'h00, R, G, B}
//   tvalid        : pixel valid
//   tready        : sink ready
//   tuser         : first pixel of frame
//   tlast         : last pixel of line
//   tstrb  [3:0]  : byte strobes
// Modports: master (pattern source), slave (sink).
// -----------------------------------------------------------------------------
interface axis_pattern_gen_if;

  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;
  logic [3:0]  tstrb;

  modport master (output tdata, tvalid, tuser, tlast, tstrb, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, tstrb, output tready);

endinterface

// File: rtl/axis_pattern_gen_pixel.sv
// -----------------------------------------------------------------------------
// pattern_pixel
// Purely combinational pixel colour generator.
//   xe_i    [7:0]  : effective column (scroll offset already applied), low bits
//   y_i     [7:0]  : line number, low bits
//   bar_i   [2:0]  : colour-bar index tracked incrementally by the caller
//   frame_i [7:0]  : frame counter, low bits (gradient blue channel)
//   sel_i          : latched pattern select
//   solid_i [23:0] : latched solid colour
//   rgb_o   [23:0] : {R, G, B}
// -----------------------------------------------------------------------------
module pattern_pixel
  import lcd_pkg::*;
(
  input  logic [7:0]  xe_i,
  input  logic [7:0]  y_i,
  input  logic [2:0]  bar_i,
  input  logic [7:0]  frame_i,
  input  pat_e        sel_i,
  input  logic [23:0] solid_i,
  output logic [23:0] rgb_o
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    rgb_o = '0;
    case (sel_i)
      PAT_BARS:  rgb_o = BAR_RGB[bar_i];
      PAT_GRAD:  rgb_o = {xe_i, y_i, frame_i};
      PAT_CHECK: rgb_o = (xe_i[4] ^ y_i[4]) ? 24'hFFFFFF : 24'h000000;
      PAT_SOLID: rgb_o = solid_i;
      default:   rgb_o = '0;
    endcase
  end

endmodule

// File: rtl/axis_pattern_gen.sv
// -----------------------------------------------------------------------------
// axis_pattern_gen
// AXI4-Stream RGB888 test-pattern source feeding the LCD FIFO. Emits whole
// frames with tuser on pixel (0,0) and tlast on the last pixel of each line,
// honours tready backpressure and inserts FRAME_GAP idle cycles between frames.
//
// Ports:
//   axis_aclk      : stream clock
//   axis_aresetn   : asynchronous active-low reset
//   enable         : run request (level); a started frame always completes
//   pattern_sel[1:0]: 0 bars, 1 gradient, 2 checkerboard, 3 solid
//   solid_rgb[23:0]: colour for the solid pattern
//   axis           : AXI4-Stream master (tdata/tvalid/tready/tuser/tlast/tstrb)
//   busy           : high whenever the sequencer is not idle
//   frame_cnt[15:0]: completed frames, wrapping
//
// Build option: define PATTERN_GEN_SCROLL_EN to add a per-frame horizontal
// offset so the picture scrolls left by one pixel per frame.
// -----------------------------------------------------------------------------
module axis_pattern_gen
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE  = 480,
  parameter int V_ACTIVE  = 272,
  parameter int FRAME_GAP = 16,
  parameter int XW        = 10
) (
  input  logic                      axis_aclk,
  input  logic                      axis_aresetn,
  input  logic                      enable,
  input  logic [1:0]                pattern_sel,
  input  logic [23:0]               solid_rgb,
  axis_pattern_gen_if.master        axis,
  output logic                      busy,
  output logic [15:0]               frame_cnt
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int GW    = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

  // Effective column plus its colour-bar position; stepping all three together
  // keeps the bar index exact without a divider.
  typedef struct packed {
    logic [XW-1:0] xe;
    logic [2:0]    bar;
    logic [XW-1:0] cnt;
  } col_t;

  // Advance one column. The last bar never advances, so it absorbs the
  // H_ACTIVE % 8 remainder columns. Wrapping past H_ACTIVE-1 restarts at bar 0.
  function automatic col_t col_step(input col_t c);
    col_t n;
    n = c;
    if (c.xe == XW'(H_ACTIVE - 1)) begin
      n = '0;
    end else begin
      n.xe = c.xe + XW'(1);
      if ((c.bar != 3'd7) && (c.cnt == XW'(BAR_W - 1))) begin
        n.bar = c.bar + 3'd1;
        n.cnt = '0;
      end else begin
        n.cnt = c.cnt + XW'(1);
      end
    end
    return n;
  endfunction

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d, y_q, y_d;
  col_t          col_q, col_d;
  col_t          off_d;
  logic [15:0]   frame_q, frame_d;
  pat_e          sel_q, sel_d;
  logic [23:0]   solid_q, solid_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          tvalid_q, tvalid_d;
  logic          tuser_q, tlast_q, busy_q;
  logic [31:0]   tdata_q;
  logic [3:0]    tstrb_q;
  logic          load, start;
  logic          xfer, x_last, y_last, frame_end;
  logic [23:0]   pix_rgb;

  assign xfer      = tvalid_q & axis.tready;
  assign x_last    = (x_q == XW'(H_ACTIVE - 1));
  assign y_last    = (y_q == XW'(V_ACTIVE - 1));
  assign frame_end = (state_q == ST_ACTIVE) & xfer & x_last & y_last;

`ifdef PATTERN_GEN_SCROLL_EN
  // Start column of every line; advances once per completed frame.
  col_t off_q;

  always_comb begin
    off_d = off_q;
    if (frame_end) off_d = col_step(off_q);
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) off_q <= '0;
    else               off_q <= off_d;
  end
`else
  assign off_d = '0;
`endif

  // Sequencer: decides the next pixel coordinates; 'load' means a new pixel is
  // registered onto the bus this edge (frame start or accepted transfer).
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    col_d    = col_q;
    frame_d  = frame_q;
    sel_d    = sel_q;
    solid_d  = solid_q;
    gap_d    = gap_q;
    tvalid_d = tvalid_q;
    load     = 1'b0;
    start    = 1'b0;

    if (frame_end) frame_d = frame_q + 16'd1;

    case (state_q)
      ST_IDLE: start = enable;

      ST_ACTIVE: begin
        if (xfer) begin
          if (x_last && y_last) begin
            if (FRAME_GAP > 0) begin
              state_d  = ST_GAP;
              gap_d    = '0;
              tvalid_d = 1'b0;
            end else if (enable) begin
              start = 1'b1;
            end else begin
              state_d  = ST_IDLE;
              tvalid_d = 1'b0;
            end
          end else if (x_last) begin
            x_d   = '0;
            y_d   = y_q + XW'(1);
            col_d = off_d;
            load  = 1'b1;
          end else begin
            x_d   = x_q + XW'(1);
            col_d = col_step(col_q);
            load  = 1'b1;
          end
        end
      end

      ST_GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(FRAME_GAP - 1)) begin
          if (enable) start = 1'b1;
          else        state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Frame start: selects are sampled here and nowhere else.
    if (start) begin
      state_d  = ST_ACTIVE;
      sel_d    = pat_e'(pattern_sel);
      solid_d  = solid_rgb;
      x_d      = '0;
      y_d      = '0;
      col_d    = off_d;
      tvalid_d = 1'b1;
      load     = 1'b1;
    end
  end

  // Colour for the pixel about to be registered, computed from next-state
  // coordinates so the bus outputs come straight from flops.
  pattern_pixel u_pixel (
    .xe_i    (8'(col_d.xe)),
    .y_i     (8'(y_d)),
    .bar_i   (col_d.bar),
    .frame_i (frame_d[7:0]),
    .sel_i   (sel_d),
    .solid_i (solid_d),
    .rgb_o   (pix_rgb)
  );

  // NOTE: every register here is reset (there is no storage array), so an
  // asserted reset clears the bus immediately and no partial frame resumes.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      col_q    <= '0;
      frame_q  <= '0;
      sel_q    <= PAT_BARS;
      solid_q  <= '0;
      gap_q    <= '0;
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tstrb_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      col_q    <= col_d;
      frame_q  <= frame_d;
      sel_q    <= sel_d;
      solid_q  <= solid_d;
      gap_q    <= gap_d;
      tvalid_q <= tvalid_d;
      busy_q   <= (state_d != ST_IDLE);
      // Without a load the payload holds, which keeps it stable under stall.
      if (load) begin
        tdata_q <= {8'h00, pix_rgb};
        tuser_q <= (x_d == '0) && (y_d == '0);
        tlast_q <= (x_d == XW'(H_ACTIVE - 1));
        tstrb_q <= TSTRB_ALL;
      end else if (!tvalid_d) begin
        tdata_q <= '0;
        tuser_q <= 1'b0;
        tlast_q <= 1'b0;
        tstrb_q <= '0;
      end
    end
  end

  assign axis.tdata  = tdata_q;
  assign axis.tvalid = tvalid_q;
  assign axis.tuser  = tuser_q;
  assign axis.tlast  = tlast_q;
  assign axis.tstrb  = tstrb_q;
  assign busy        = busy_q;
  assign frame_cnt   = frame_q;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_axis_pattern_gen
// Self-checking bench for axis_pattern_gen with an 8x4 frame and a 2-cycle gap.
// Expected pixels come from an independent frame model pushed into a queue when
// a frame is scheduled and popped on every observed transfer.
// -----------------------------------------------------------------------------
module tb_axis_pattern_gen;
  import lcd_pkg::*;

  localparam int H      = 8;
  localparam int V      = 4;
  localparam int G      = 2;
  localparam int XW     = 10;
  localparam int BUDGET = 2000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  sel;
  logic [23:0] solid;
  logic        busy;
  logic [15:0] frame_cnt;

  axis_pattern_gen_if axis ();

  axis_pattern_gen #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .FRAME_GAP (G),
    .XW        (XW)
  ) dut (
    .axis_aclk    (clk),
    .axis_aresetn (rst_n),
    .enable       (enable),
    .pattern_sel  (sel),
    .solid_rgb    (solid),
    .axis         (axis),
    .busy         (busy),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tdata;
    logic        tuser;
    logic        tlast;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_frame  = 0;
  int   m_off    = 0;
  int   beat_idx = 0;

  function automatic logic [23:0] model_rgb(input logic [1:0] s, input logic [23:0] sol,
                                            input int x, input int y, input int fc, input int off);
    logic [23:0] bars [8];
    int xe, b;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    xe = (x + off) % H;
    b  = xe / (H / 8);
    if (b > 7) b = 7;
    case (s)
      2'd0:    return bars[b];
      2'd1:    return {8'(xe), 8'(y), 8'(fc)};
      2'd2:    return ((((xe >> 4) ^ (y >> 4)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: return sol;
    endcase
  endfunction

  task automatic push_frame(input logic [1:0] s, input logic [23:0] sol);
    exp_t e;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        e.tdata = {8'h00, model_rgb(s, sol, x, y, m_frame, m_off)};
        e.tuser = (x == 0) && (y == 0);
        e.tlast = (x == H - 1);
        exp_q.push_back(e);
      end
    end
    m_frame = (m_frame + 1) % 65536;
`ifdef PATTERN_GEN_SCROLL_EN
    m_off = (m_off + 1) % H;
`endif
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    enable      = 1'b0;
    axis.tready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    m_frame  = 0;
    m_off    = 0;
    beat_idx = 0;
  endtask

  // Accept n beats; tready is random when rnd is set. Checks each beat against
  // the scoreboard and checks payload stability across every stalled cycle.
  task automatic consume(input int n, input bit rnd, input string tag);
    int   got, cycles;
    bit   stalled;
    exp_t held, e;
    got = 0; cycles = 0; stalled = 1'b0;
    while (got < n && cycles < BUDGET) begin
      @(posedge clk);
      #1 axis.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cycles++;
      if (stalled) begin
        n_checks++;
        if (axis.tvalid !== 1'b1 || axis.tdata !== held.tdata ||
            axis.tuser !== held.tuser || axis.tlast !== held.tlast) begin
          n_fail++;
          $display("FAIL %s stall_hold: got v=%b d=%h u=%b l=%b, want v=1 d=%h u=%b l=%b",
                   tag, axis.tvalid, axis.tdata, axis.tuser, axis.tlast,
                   held.tdata, held.tuser, held.tlast);
        end
        stalled = 1'b0;
      end
      if (!axis.tvalid && (beat_idx % (H * V)) != 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s valid_in_frame: tvalid low after beat %0d", tag, beat_idx);
      end
      if (axis.tvalid) begin
        if (axis.tready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s extra_beat: got d=%h, want no beat", tag, axis.tdata);
          end else begin
            e = exp_q.pop_front();
            if (axis.tdata !== e.tdata) begin
              n_fail++;
              $display("FAIL %s tdata beat %0d: got %h, want %h", tag, beat_idx, axis.tdata, e.tdata);
            end
            n_checks++;
            if ({axis.tuser, axis.tlast, axis.tstrb} !== {e.tuser, e.tlast, 4'hF}) begin
              n_fail++;
              $display("FAIL %s flags beat %0d: got u=%b l=%b s=%h, want u=%b l=%b s=f",
                       tag, beat_idx, axis.tuser, axis.tlast, axis.tstrb, e.tuser, e.tlast);
            end
          end
          got++;
          beat_idx++;
        end else begin
          stalled    = 1'b1;
          held.tdata = axis.tdata;
          held.tuser = axis.tuser;
          held.tlast = axis.tlast;
        end
      end
    end
    if (got < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: got %0d beats, want %0d", tag, got, n);
    end
  endtask

  task automatic test_reset();
    sel   = PAT_BARS;
    solid = 24'h0;
    rst_n = 1'b0;
    enable = 1'b0;
    axis.tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset tvalid: got %b, want 0", axis.tvalid); end
    n_checks++;
    if (axis.tdata !== 32'h0) begin n_fail++; $display("FAIL reset tdata: got %h, want 0", axis.tdata); end
    n_checks++;
    if (axis.tstrb !== 4'h0) begin n_fail++; $display("FAIL reset tstrb: got %h, want 0", axis.tstrb); end
    n_checks++;
    if ({axis.tuser, axis.tlast} !== 2'b00) begin n_fail++; $display("FAIL reset user_last: got %b%b, want 00", axis.tuser, axis.tlast); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b, want 0", busy); end
    n_checks++;
    if (frame_cnt !== 16'h0) begin n_fail++; $display("FAIL reset frame_cnt: got %h, want 0", frame_cnt); end
  endtask

  task automatic test_first_frame();
    int low;
    apply_reset();
    sel = PAT_BARS;
    @(posedge clk);
    #1 enable = 1'b1;
    push_frame(PAT_BARS, 24'h0);
    @(negedge clk);
    n_checks++;
    if (axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL latency_pre: tvalid got %b, want 0", axis.tvalid); end
    @(posedge clk);
    #1;
    n_checks++;
    if ({axis.tvalid, axis.tuser, axis.tdata} !== {1'b1, 1'b1, 32'h00FFFFFF}) begin
      n_fail++;
      $display("FAIL latency_first: got v=%b u=%b d=%h, want v=1 u=1 d=00ffffff", axis.tvalid, axis.tuser, axis.tdata);
    end
    consume(H * V, 1'b0, "frame0");
    push_frame(PAT_BARS, 24'h0);
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 axis.tready = 1'b0;
      @(negedge clk);
      if (axis.tvalid) break;
      if (low == 0) begin
        n_checks++;
        if (frame_cnt !== 16'd1 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL gap_state: got frame_cnt=%0d busy=%b, want 1 1", frame_cnt, busy);
        end
      end
      low++;
    end
    n_checks++;
    if (low != G) begin n_fail++; $display("FAIL gap_len: got %0d low cycles, want %0d", low, G); end
  endtask

  task automatic test_backpressure();
    consume(16, 1'b1, "bp_a");
    sel = PAT_CHECK;
    consume(H * V - 16, 1'b1, "bp_b");
  endtask

  task automatic test_select_switch();
    apply_reset();
    sel   = PAT_SOLID;
    solid = 24'h123456;
    push_frame(PAT_SOLID, 24'h123456);
    push_frame(PAT_GRAD, 24'h123456);
    @(posedge clk);
    #1 enable = 1'b1;
    consume(5, 1'b0, "solid_a");
    sel = PAT_GRAD;
    consume(H * V - 5, 1'b0, "solid_b");
    consume(H * V, 1'b1, "grad");
  endtask

  task automatic test_enable_drop();
    int vcnt;
    apply_reset();
    sel = PAT_GRAD;
    push_frame(PAT_GRAD, 24'h0);
    @(posedge clk);
    #1 enable = 1'b1;
    consume(10, 1'b0, "drop_a");
    enable = 1'b0;
    consume(H * V - 10, 1'b0, "drop_b");
    vcnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1 axis.tready = 1'b1;
      @(negedge clk);
      if (axis.tvalid) vcnt++;
      if (k == 1) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL drop_busy_gap: got %b, want 1", busy); end
      end
      if (k == 3) begin
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy_idle: got %b, want 0", busy); end
      end
    end
    n_checks++;
    if (vcnt != 0) begin n_fail++; $display("FAIL drop_no_restart: got %0d valid cycles, want 0", vcnt); end
    n_checks++;
    if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL drop_frame_cnt: got %0d, want 1", frame_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    sel = PAT_BARS;
    push_frame(PAT_BARS, 24'h0);
    push_frame(PAT_BARS, 24'h0);
    @(posedge clk);
    #1 enable = 1'b1;
    consume(H * V + 17, 1'b0, "pre_rst");
    n_checks++;
    if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL pre_rst_frame_cnt: got %0d, want 1", frame_cnt); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({axis.tvalid, busy, frame_cnt} !== {1'b0, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL async_clear: got v=%b busy=%b fc=%h, want 0 0 0", axis.tvalid, busy, frame_cnt);
    end
    n_checks++;
    if ({axis.tuser, axis.tlast, axis.tstrb} !== 6'b0) begin
      n_fail++;
      $display("FAIL async_clear_flags: got u=%b l=%b s=%h, want 0 0 0", axis.tuser, axis.tlast, axis.tstrb);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    m_frame  = 0;
    m_off    = 0;
    beat_idx = 0;
    push_frame(PAT_BARS, 24'h0);
    consume(H * V, 1'b0, "post_rst");
  endtask

`ifdef PATTERN_GEN_SCROLL_EN
  task automatic test_scroll();
    apply_reset();
    sel = PAT_GRAD;
    for (int f = 0; f < H + 1; f++) push_frame(PAT_GRAD, 24'h0);
    @(posedge clk);
    #1 enable = 1'b1;
    consume((H + 1) * H * V, 1'b1, "scroll");
    enable = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_first_frame();
    test_backpressure();
    test_select_switch();
    test_enable_drop();
    test_reset_mid_frame();
`ifdef PATTERN_GEN_SCROLL_EN
    test_scroll();
`endif
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_beats: got %0d unconsumed, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_pattern_gen.md
# axis_pattern_gen

AXI4-Stream video test-pattern source that sits directly upstream of `lcd_top`, driving its `axis_*` slave port in place of a camera/DMA stream. It emits complete RGB888 frames, with `tuser` on the first pixel of each frame and `tlast` on the last pixel of each line, honouring `tready` backpressure from the LCD FIFO. It is used for panel bring-up and for verifying the FIFO and LCD timing path.

## Interface
Parameters:
- `H_ACTIVE`, 480: pixels per line.
- `V_ACTIVE`, 272: lines per frame.
- `FRAME_GAP`, 16: idle cycles between frames (`tvalid` low); 0 is legal.
- `XW`, 10: x/y counter width; must satisfy `2^XW >= max(H_ACTIVE, V_ACTIVE)`.

Ports:
- `axis_aclk`, in, 1: stream clock. One clock domain only.
- `axis_aresetn`, in, 1: reset, asynchronous assert, active-low.
- `enable`, in, 1: run request, level-sensitive.
- `pattern_sel`, in, 2: 0 colour bars, 1 gradient, 2 checkerboard, 3 solid.
- `solid_rgb`, in, 24: colour used when `pattern_sel=3`.
- `axis_tdata`, out, 32: `{8'h00, R[7:0], G[7:0], B[7:0]}`.
- `axis_tvalid`, out, 1: pixel valid.
- `axis_tready`, in, 1: sink ready.
- `axis_tuser`, out, 1: first pixel of frame.
- `axis_tlast`, out, 1: last pixel of line.
- `axis_tstrb`, out, 4: constant `4'hF` while valid, 0 otherwise.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `frame_cnt`, out, 16: number of completed frames; wraps from FFFF to 0.

## Operation
- State machine: IDLE → ACTIVE → GAP → ACTIVE/IDLE.
  - IDLE: `tvalid=0`. When `enable=1`, latch `pattern_sel` and `solid_rgb`, set x=y=0, go to ACTIVE.
  - ACTIVE: present pixel (x,y). A transfer is a cycle with `tvalid & tready`; on each transfer, x increments.
  - At x=H_ACTIVE-1, x wraps to 0 and y increments.
  - On transfer of (H_ACTIVE-1, V_ACTIVE-1): `frame_cnt` increments.
    - If `FRAME_GAP>0`, go to GAP.
    - Otherwise go to ACTIVE (if `enable=1`) or IDLE, relatching the selects.
  - GAP: count `FRAME_GAP` cycles, then go to ACTIVE if `enable=1` (relatch selects), else IDLE.
- Deasserting `enable` mid-frame never truncates a frame; the current frame always completes.
- Selects are sampled only at frame start; changes mid-frame have no effect.
- `tuser=1` only at (0,0); `tlast=1` only at x=H_ACTIVE-1.
- Patterns, using the effective x (xe):
  - Colour bars: 8 bars, each H_ACTIVE/8 wide (integer division); the remainder columns belong to the last bar. Order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. Bar index comes from an incremental bar counter; no divider.
  - Gradient: R=xe[7:0], G=y[7:0], B=frame_cnt[7:0].
  - Checkerboard: FFFFFF if `xe[4]^y[4]`, else 000000.
  - Solid: the latched `solid_rgb`.

## Timing
- All outputs are registered. Reset values: `tvalid`, `tuser`, `tlast`, `busy`=0; `tdata`=0; `tstrb`=0; `frame_cnt`=0; state IDLE; x=y=0.
- IDLE with `enable=1` at edge N gives `tvalid=1` with pixel (0,0) after edge N+1 (1-cycle latency).
- While `tvalid=1 & tready=0`, `tdata`, `tuser`, `tlast` and `tstrb` hold stable (AXI rule).
- `tvalid` never deasserts inside a frame.
- Sustained throughput is 1 pixel/cycle with `tready` held high.
- The last transfer of a frame and the next `tvalid` are separated by exactly `FRAME_GAP` low cycles.
- Reset asserted mid-frame: all outputs clear immediately (asynchronously). After release, the block restarts from IDLE; no partial-frame resume.

## Configuration
- `PATTERN_GEN_SCROLL_EN` defined:
  - A per-frame offset register increments by 1 at each frame end and wraps H_ACTIVE-1 → 0.
  - xe = (x+offset) wrapped modulo H_ACTIVE using a compare-subtract, no divider.
  - The pattern scrolls left one pixel per frame.
- Undefined: offset logic is removed and xe=x.

## Structure
- Package `lcd_pkg`:
  - Pattern-select encodings `PAT_BARS`, `PAT_GRAD`, `PAT_CHECK`, `PAT_SOLID`.
  - Bar colour constant array.
  - State encoding `ST_IDLE`, `ST_ACTIVE`, `ST_GAP`.
- Sub-module `pattern_pixel`: combinational RGB from (xe, y, bar index, frame_cnt, latched selects). The top level owns the FSM, counters and output registers.

## Test plan
- Reset with H_ACTIVE=8, V_ACTIVE=4, FRAME_GAP=2, `enable=1`, `tready=1`:
  - 32 transfers; `tuser` only on transfer 0; `tlast` on transfers 7, 15, 23, 31.
  - Then exactly 2 low-`tvalid` cycles; `frame_cnt`=1.
- Random `tready` (50%) with bars: outputs stable while stalled.
  - Bar sequence per line is FFFFFF, FFFF00, …, 000000 (one pixel each).
- Switch `pattern_sel` 3→1 at pixel 5 with `solid_rgb`=123456: the current frame stays all 123456; the next frame is the gradient with B=01.
- Drop `enable` at pixel 10: the frame completes through pixel 31, then GAP, then IDLE with `busy`=0.
- Assert `axis_aresetn` low at pixel 17: `tvalid`, `busy` and `frame_cnt` go to 0 at once; after release, the first pixel out is (0,0) with `tuser=1`.
- `PATTERN_GEN_SCROLL_EN`, checkerboard, H_ACTIVE=32: frame 1 pixel (0,0) equals frame 0 pixel (1,0); the offset wraps to 0 after 32 frames.
